mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single `sys` memory port (`req`/`wr`/`addr`/`dout`/`din`/`rdy`) between N requester cores, for example several seeded increment engines running read-modify-write traffic. It grants one requester at a time and latches that requester's command. It drives the memory-side level handshake until `rdy`, then returns read data and a one-cycle acknowledge to the granted requester. A watchdog flags a memory that never answers.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter_if: requester-side and memory-side bus bundle     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mem_port_arbiter_if #(
   parameter int N  = 4,
   parameter int AW = 64,
   parameter int DW = 64
);
   logic [N-1:0]    r_req;
   logic [N-1:0]    r_wr;
   logic [N*AW-1:0] r_addr;
   logic [N*DW-1:0] r_dout;
   logic [DW-1:0]   r_din;
   logic [N-1:0]    r_rdy;
   logic            m_req;
   logic            m_wr;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_dout;
   logic [DW-1:0]   m_din;
   logic            m_rdy;
   logic            err;

   modport master (
      input  r_req, r_wr, r_addr, r_dout, m_din, m_rdy,
      output r_din, r_rdy, m_req, m_wr, m_addr, m_dout, err
   );

   modport slave (
      output r_req, r_wr, r_addr, r_dout, m_din, m_rdy,
      input  r_din, r_rdy, m_req, m_wr, m_addr, m_dout, err
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter: round-robin sharing of one memory port among N   |
// | requesters, with latched commands and a sticky timeout watchdog.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int N       = 4,
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
   localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   gnt_q, gnt_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   logic            m_req_q, m_req_d;
   logic            m_wr_q, m_wr_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_dout_q, m_dout_d;
   logic [DW-1:0]   r_din_q, r_din_d;
   logic [N-1:0]    r_rdy_q, r_rdy_d;
   logic            err_q, err_d;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [WW-1:0]   wdog_inc;

   // Scan downward so the candidate closest to last+1 is the one that sticks.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = N; k >= 1; k--) begin
         int idx;
         idx = (int'(last_q) + k) % N;
         if (bus.r_req[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(idx);
         end
      end
   end

   assign wdog_inc = wdog_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      wdog_d   = wdog_q;
      m_req_d  = m_req_q;
      m_wr_d   = m_wr_q;
      m_addr_d = m_addr_q;
      m_dout_d = m_dout_q;
      r_din_d  = r_din_q;
      r_rdy_d  = '0;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               gnt_d    = pick_idx;
               m_wr_d   = bus.r_wr[pick_idx];
               m_addr_d = bus.r_addr[pick_idx*AW +: AW];
               m_dout_d = bus.r_dout[pick_idx*DW +: DW];
               m_req_d  = 1'b1;
               wdog_d   = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            wdog_d = wdog_inc;
            if (bus.m_rdy) begin
               m_req_d        = 1'b0;
               r_rdy_d[gnt_q] = 1'b1;
               if (!m_wr_q) begin
                  r_din_d = bus.m_din;
               end
               last_d  = gnt_q;
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (wdog_inc == WD_LIMIT)) begin
               // Abandon the access but still acknowledge so the requester is not stranded.
               err_d          = 1'b1;
               m_req_d        = 1'b0;
               r_rdy_d[gnt_q] = 1'b1;
               last_d         = gnt_q;
               state_d        = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_q   <= LAST_RST;
         gnt_q    <= '0;
         wdog_q   <= '0;
         m_req_q  <= 1'b0;
         m_wr_q   <= 1'b0;
         m_addr_q <= '0;
         m_dout_q <= '0;
         r_din_q  <= '0;
         r_rdy_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         wdog_q   <= wdog_d;
         m_req_q  <= m_req_d;
         m_wr_q   <= m_wr_d;
         m_addr_q <= m_addr_d;
         m_dout_q <= m_dout_d;
         r_din_q  <= r_din_d;
         r_rdy_q  <= r_rdy_d;
         err_q    <= err_d;
      end
   end

   assign bus.m_req  = m_req_q;
   assign bus.m_wr   = m_wr_q;
   assign bus.m_addr = m_addr_q;
   assign bus.m_dout = m_dout_q;
   assign bus.r_din  = r_din_q;
   assign bus.r_rdy  = r_rdy_q;
   assign bus.err    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed self-checking bench for the arbiter  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;
   localparam int N   = 4;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int TMO = 8;
   localparam int RMW_PER_PORT = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus();

   mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [N-1:0]    req;
   logic [N-1:0]    wr;
   logic [AW-1:0]   addr [N];
   logic [DW-1:0]   dout [N];
   logic [N*AW-1:0] addr_flat;
   logic [N*DW-1:0] dout_flat;

   always_comb begin
      addr_flat = '0;
      dout_flat = '0;
      for (int i = 0; i < N; i++) begin
         addr_flat[i*AW +: AW] = addr[i];
         dout_flat[i*DW +: DW] = dout[i];
      end
   end

   // Memory model: answers after a per-direction latency with a one-cycle m_rdy.
   logic          m_rdy = 1'b0;
   logic [DW-1:0] m_din = '0;
   logic [DW-1:0] mem [256];
   bit            mem_en;
   int            rlat, wlat, mcnt, wcount;

   assign bus.r_req  = req;
   assign bus.r_wr   = wr;
   assign bus.r_addr = addr_flat;
   assign bus.r_dout = dout_flat;
   assign bus.m_rdy  = m_rdy;
   assign bus.m_din  = m_din;

   always @(negedge clk) begin
      if (m_rdy) begin
         m_rdy = 1'b0;
         mcnt  = 0;
      end else if (!bus.m_req || !mem_en) begin
         mcnt = 0;
      end else begin
         mcnt++;
         if (mcnt >= (bus.m_wr ? wlat : rlat)) begin
            m_rdy = 1'b1;
            mcnt  = 0;
            if (bus.m_wr) begin
               mem[bus.m_addr[7:0]] = bus.m_dout;
               wcount++;
            end else begin
               m_din = mem[bus.m_addr[7:0]];
            end
         end
      end
   end

   int pass_cnt = 0;
   int total    = 0;

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.m_req !== 1'b0) $display("FAIL reset_m_req: got %0h want 0", bus.m_req); else pass_cnt++;
      total++; if (bus.m_wr !== 1'b0) $display("FAIL reset_m_wr: got %0h want 0", bus.m_wr); else pass_cnt++;
      total++; if (bus.m_addr !== 64'h0) $display("FAIL reset_m_addr: got %0h want 0", bus.m_addr); else pass_cnt++;
      total++; if (bus.m_dout !== 64'h0) $display("FAIL reset_m_dout: got %0h want 0", bus.m_dout); else pass_cnt++;
      total++; if (bus.r_din !== 64'h0) $display("FAIL reset_r_din: got %0h want 0", bus.r_din); else pass_cnt++;
      total++; if (bus.r_rdy !== 4'h0) $display("FAIL reset_r_rdy: got %0h want 0", bus.r_rdy); else pass_cnt++;
      total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %0h want 0", bus.err); else pass_cnt++;
   endtask

   task automatic test_single_read();
      int n;
      mem[8'h10] = 64'hDEAD_BEEF_0000_0001;
      rlat = 3; mem_en = 1'b1;
      addr[2] = 64'h10; wr[2] = 1'b0; req[2] = 1'b1;
      @(negedge clk);
      total++; if (bus.m_req !== 1'b1) $display("FAIL rd_m_req: got %0h want 1", bus.m_req); else pass_cnt++;
      total++; if (bus.m_addr !== 64'h10) $display("FAIL rd_m_addr: got %0h want 10", bus.m_addr); else pass_cnt++;
      total++; if (bus.m_wr !== 1'b0) $display("FAIL rd_m_wr: got %0h want 0", bus.m_wr); else pass_cnt++;
      n = 1;
      while (bus.r_rdy === 4'h0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (n != 4) $display("FAIL rd_latency: got %0d want 4", n); else pass_cnt++;
      total++; if (bus.r_rdy !== 4'b0100) $display("FAIL rd_r_rdy: got %b want 0100", bus.r_rdy); else pass_cnt++;
      total++; if (bus.r_din !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rd_r_din: got %h want deadbeef00000001", bus.r_din); else pass_cnt++;
      total++; if (bus.m_req !== 1'b0) $display("FAIL rd_m_req_drop: got %0h want 0", bus.m_req); else pass_cnt++;
      req[2] = 1'b0;
      @(negedge clk);
      total++; if (bus.r_rdy !== 4'h0) $display("FAIL rd_r_rdy_pulse: got %b want 0000", bus.r_rdy); else pass_cnt++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      int grants, low;
      logic prev;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rlat = 1; mem_en = 1'b1;
      for (int i = 0; i < N; i++) begin
         addr[i] = 64'h100 * i + 64'h80;
         wr[i]   = 1'b0;
      end
      req = 4'hF;
      grants = 0; low = 0; prev = 1'b0;
      for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
         @(negedge clk);
         if (bus.m_req && !prev) begin
            total++;
            if (bus.m_addr[9:8] !== 2'(grants % 4))
               $display("FAIL rr_order[%0d]: got port %0d want %0d", grants, bus.m_addr[9:8], grants % 4);
            else pass_cnt++;
            if (grants > 0) begin
               total++;
               if (low != 2) $display("FAIL rr_gap[%0d]: got %0d want 2", grants, low); else pass_cnt++;
            end
            grants++;
            low = 0;
         end else if (!bus.m_req) begin
            low++;
         end
         prev = bus.m_req;
         for (int i = 0; i < N; i++) begin
            if (bus.r_rdy[i]) req[i] = 1'b0;
            else if (!req[i]) req[i] = 1'b1;
         end
      end
      total++; if (grants != 8) $display("FAIL rr_grants: got %0d want 8", grants); else pass_cnt++;
      req = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_rmw();
      int done [2];
      int exp_cnt [256];
      int bad;
      for (int a = 0; a < 256; a++) begin
         mem[a] = '0;
         exp_cnt[a] = 0;
      end
      wcount = 0; wlat = 5; rlat = 2; mem_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         done[i] = 0;
         addr[i] = 64'($urandom_range(0, 127)) * 2 + 64'(i);
         wr[i]   = 1'b0;
         req[i]  = 1'b1;
      end
      for (int cyc = 0; cyc < 60000 && !(done[0] == RMW_PER_PORT && done[1] == RMW_PER_PORT); cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (bus.r_rdy[i]) begin
               req[i] = 1'b0;
               if (!wr[i]) begin
                  wr[i]   = 1'b1;
                  dout[i] = bus.r_din + 64'd1;
               end else begin
                  exp_cnt[addr[i][7:0]]++;
                  done[i]++;
                  wr[i]   = 1'b0;
                  addr[i] = 64'($urandom_range(0, 127)) * 2 + 64'(i);
               end
            end else if (!req[i] && done[i] < RMW_PER_PORT) begin
               req[i] = 1'b1;
            end
         end
      end
      repeat (4) @(negedge clk);
      bad = 0;
      for (int a = 0; a < 256; a++)
         if (mem[a] !== 64'(exp_cnt[a])) bad++;
      total++; if (done[0] != RMW_PER_PORT) $display("FAIL rmw_done0: got %0d want %0d", done[0], RMW_PER_PORT); else pass_cnt++;
      total++; if (done[1] != RMW_PER_PORT) $display("FAIL rmw_done1: got %0d want %0d", done[1], RMW_PER_PORT); else pass_cnt++;
      total++; if (wcount != 2 * RMW_PER_PORT) $display("FAIL rmw_writes: got %0d want %0d", wcount, 2 * RMW_PER_PORT); else pass_cnt++;
      total++; if (bad != 0) $display("FAIL rmw_contents: got %0d bad words want 0", bad); else pass_cnt++;
      total++; if (bus.err !== 1'b0) $display("FAIL rmw_err: got %0h want 0", bus.err); else pass_cnt++;
      req = '0; wr = '0;
   endtask

   task automatic test_cmd_latch();
      int n;
      mem[8'h20] = 64'hAAAA_0020;
      mem[8'h30] = 64'hBBBB_0030;
      rlat = 5; mem_en = 1'b1;
      addr[1] = 64'h20; wr[1] = 1'b0; req[1] = 1'b1;
      @(negedge clk);
      total++; if (bus.m_addr !== 64'h20) $display("FAIL latch_grant_addr: got %0h want 20", bus.m_addr); else pass_cnt++;
      addr[1] = 64'h30;
      n = 0;
      while (bus.r_rdy === 4'h0 && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.m_req) begin
            total++; if (bus.m_addr !== 64'h20) $display("FAIL latch_addr: got %0h want 20", bus.m_addr); else pass_cnt++;
         end
      end
      total++; if (bus.r_rdy !== 4'b0010) $display("FAIL latch_r_rdy: got %b want 0010", bus.r_rdy); else pass_cnt++;
      total++; if (bus.r_din !== 64'hAAAA_0020) $display("FAIL latch_r_din: got %h want aaaa0020", bus.r_din); else pass_cnt++;
      req[1] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_watchdog();
      int n, busy;
      total++; if (bus.err !== 1'b0) $display("FAIL wd_err_pre: got %0h want 0", bus.err); else pass_cnt++;
      mem_en = 1'b0;
      addr[3] = 64'h40; wr[3] = 1'b0; req[3] = 1'b1;
      n = 0; busy = 0;
      while (bus.r_rdy === 4'h0 && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.m_req) busy++;
      end
      total++; if (busy != TMO) $display("FAIL wd_busy_cycles: got %0d want %0d", busy, TMO); else pass_cnt++;
      total++; if (bus.r_rdy !== 4'b1000) $display("FAIL wd_r_rdy: got %b want 1000", bus.r_rdy); else pass_cnt++;
      total++; if (bus.err !== 1'b1) $display("FAIL wd_err: got %0h want 1", bus.err); else pass_cnt++;
      total++; if (bus.r_din !== 64'hAAAA_0020) $display("FAIL wd_r_din: got %h want aaaa0020", bus.r_din); else pass_cnt++;
      total++; if (bus.m_req !== 1'b0) $display("FAIL wd_m_req: got %0h want 0", bus.m_req); else pass_cnt++;
      req[3] = 1'b0;
      mem_en = 1'b1; rlat = 2;
      mem[8'h50] = 64'h5555;
      addr[0] = 64'h50; wr[0] = 1'b0;
      @(negedge clk);
      req[0] = 1'b1;
      n = 0;
      while (bus.r_rdy === 4'h0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (bus.r_rdy !== 4'b0001) $display("FAIL wd_next_r_rdy: got %b want 0001", bus.r_rdy); else pass_cnt++;
      total++; if (bus.r_din !== 64'h5555) $display("FAIL wd_next_r_din: got %h want 5555", bus.r_din); else pass_cnt++;
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.err !== 1'b1) $display("FAIL wd_err_sticky: got %0h want 1", bus.err); else pass_cnt++;
   endtask

   task automatic test_reset_mid_busy();
      mem_en = 1'b0;
      addr[2] = 64'h60; addr[0] = 64'h70;
      wr[2] = 1'b0; wr[0] = 1'b0;
      req[2] = 1'b1;
      @(negedge clk);
      total++; if (bus.m_req !== 1'b1) $display("FAIL rstb_busy: got %0h want 1", bus.m_req); else pass_cnt++;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (bus.m_req !== 1'b0) $display("FAIL rstb_m_req: got %0h want 0", bus.m_req); else pass_cnt++;
      total++; if (bus.r_rdy !== 4'h0) $display("FAIL rstb_r_rdy: got %b want 0000", bus.r_rdy); else pass_cnt++;
      total++; if (bus.err !== 1'b0) $display("FAIL rstb_err: got %0h want 0", bus.err); else pass_cnt++;
      total++; if (bus.m_addr !== 64'h0) $display("FAIL rstb_m_addr: got %0h want 0", bus.m_addr); else pass_cnt++;
      req[0] = 1'b1;
      @(negedge clk);
      total++; if (bus.r_rdy !== 4'h0) $display("FAIL rstb_r_rdy_hold: got %b want 0000", bus.r_rdy); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.m_req !== 1'b1) $display("FAIL rstb_regrant: got %0h want 1", bus.m_req); else pass_cnt++;
      total++; if (bus.m_addr !== 64'h70) $display("FAIL rstb_port0: got %0h want 70", bus.m_addr); else pass_cnt++;
      mem_en = 1'b1; rlat = 1;
      req = '0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      req = '0; wr = '0;
      for (int i = 0; i < N; i++) begin
         addr[i] = '0;
         dout[i] = '0;
      end
      for (int a = 0; a < 256; a++) mem[a] = '0;
      mem_en = 1'b0; rlat = 1; wlat = 1; mcnt = 0; wcount = 0;
      test_reset();
      test_single_read();
      test_simultaneous();
      test_rmw();
      test_cmd_latch();
      test_watchdog();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
`default_nettype wire
